chip8_mem_arb: RTL and testbench
================================

# chip8_mem_arb

Memory arbiter and access sequencer for the Chip-8 core's single-port 4 KiB program/data RAM. It serialises three requesters onto one synchronous RAM port: the program uploader (write-only, highest priority), the blitter and the CPU. It sits inside the `chip8` machine between the upload path, CPU, blitter and the RAM macro. It replaces ad-hoc muxing with a req/ack handshake and a small upload write buffer.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: upload write buffer entries (power of two, ≥2).

Ports:
- `clk`  in  1  system clock; every transfer is synchronous to its rising edge.
- `res_n`  in  1  reset; **asynchronous, active-low**.
- `uploading`  in  1  upload session active, synchronous to `clk`.
- `up_we`  in  1  single-cycle upload write strobe, already synchronised to `clk`.
- `up_a`  in  12  upload address.
- `up_d`  in  8  upload data.
- `up_overflow`  out  1  sticky: an upload strobe was dropped.
- `cpu_req`, `cpu_we`  in  1  CPU request / write-not-read.
- `cpu_a`  in  12  CPU address.
- `cpu_d`  in  8  CPU write data.
- `cpu_ack`  out  1  CPU access-complete pulse.
- `cpu_q`  out  8  CPU read data.
- `blt_req`, `blt_we`, `blt_a`, `blt_d`, `blt_ack`, `blt_q`: same as the CPU signals, for the blitter.
- `ram_en`, `ram_we`  out  1  RAM port controls.
- `ram_a`  out  12  RAM address.
- `ram_d`  out  8  RAM write data.
- `ram_q`  in  8  RAM read data; registered, valid the cycle after `ram_en`.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- Requester handshake:
  - Hold `req`, `we`, `a` and `d` stable until `ack`.
  - `ack` is a one-cycle pulse. `q` is valid from the `ack` cycle and is held until that requester's next read ack.
  - In its `ack` cycle a requester is ineligible for a grant. `req` still high in the following cycle starts a new transaction.
- Upload path:
  - Each `up_we` pushes {a,d} into the FIFO.
  - Push when full: entry dropped, `up_overflow` ← 1.
  - `up_overflow` clears only on `res_n` or a rising edge of `uploading`.
- FSM states: IDLE, ACCESS, CAPTURE.
  - IDLE: pick a winner in priority order:
    - FIFO non-empty: pop the FIFO and go to ACCESS (upload write).
    - Else, if `uploading` = 0: choose between blitter and CPU per Configuration, then go to ACCESS.
    - Else: stay in IDLE.
  - ACCESS: `ram_en` = 1, `ram_we`/`ram_a`/`ram_d` from the winner.
    - Upload write or requester write: go to IDLE, pulse the winner's ack in that IDLE cycle (no ack for upload).
    - Read: go to CAPTURE.
  - CAPTURE: load `ram_q` into the winner's `q` register, pulse ack in the next (IDLE) cycle.
- While `uploading` = 1, CPU and blitter requests stay pending, never granted. An in-flight access completes normally.
- All RAM outputs are registered. `ram_en`, `ram_we` = 0 outside ACCESS. `ram_a`/`ram_d` hold their last value.

## Timing
- Reset (async assert, sync release): state IDLE, FIFO empty. All outputs are 0: `ram_en`, `ram_we`, `ram_a`, `ram_d`, acks, `cpu_q`, `blt_q`, `up_overflow`, `busy`.
- Reset mid-access aborts it: no ack is ever issued for that request.
- Read: req sampled high in IDLE at edge E0; ACCESS in cycle E0..E1; CAPTURE E1..E2; ack and `q` visible E2..E3. Latency 3 cycles.
- Write: ack visible E1..E2. Latency 2 cycles.
- Upload write: occupies 2 cycles. A push and pop on the same edge are both honoured; occupancy is unchanged.
- `uploading` falling: grants resume only after the FIFO drains.

## Configuration
- `CHIP8_ARB_RR_EN` defined: round-robin between blitter and CPU. A 1-bit last-grant register is initialised to CPU at reset, so blitter wins the first tie. The loser of a tie wins the next tie.
- Not defined: fixed priority, blitter always beats CPU.
- Upload priority is identical in both builds.

## Structure
- Shared header `chip8_mem.vh`: `ADDR_W`=12, `DATA_W`=8, FSM state encodings, requester IDs (UPLOAD=0, BLT=1, CPU=2).
- Sub-module `chip8_upload_fifo`: synchronous FIFO with push/pop/full/empty. The arbiter owns the overflow flag.

## Test plan
- CPU read of 0x200 preloaded 0xA2: `ram_en` for one cycle one cycle after the sample edge; `cpu_ack` pulses at +3; `cpu_q` = 0xA2, held afterwards.
- Blitter writes 0x5C to 0x3F0, then CPU reads 0x3F0: `blt_ack` at +2; CPU read returns 0x5C.
- `cpu_req` and `blt_req` held high continuously for 6 transactions:
  - without `CHIP8_ARB_RR_EN`, `blt_ack` only (CPU starved);
  - with it, acks alternate BLT, CPU, BLT, CPU, …
- `uploading` = 1, 16 strobes spaced 2 cycles apart (0x200..0x20F, data = index), `cpu_req` pending: all 16 bytes land, `up_overflow` = 0, no `cpu_ack` until `uploading` = 0 and FIFO empty.
- 8 `up_we` strobes on consecutive cycles: `up_overflow` = 1 and stays set until `uploading` rises again.
- `res_n` pulled low during ACCESS of a CPU read: no `cpu_ack`, all outputs 0 immediately; after release, a fresh request completes normally.

Source files
------------

// File: rtl/chip8_mem_arb_pkg.sv
// Shared widths, FSM states and requester IDs for the Chip-8 RAM arbiter.
package chip8_mem_arb_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StCapture = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        ReqUpload = 2'd0,
        ReqBlt    = 2'd1,
        ReqCpu    = 2'd2
    } req_id_e;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } up_entry_t;

endpackage

// File: rtl/chip8_mem_arb_upload_fifo.sv
// Small synchronous FIFO buffering upload writes; pushes while full are ignored here
// and flagged by the arbiter.
module chip8_mem_arb_upload_fifo
    import chip8_mem_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      res_n,
    input  logic      push,
    input  up_entry_t push_data,
    input  logic      pop,
    output up_entry_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(FIFO_DEPTH);

    up_entry_t       mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            push_ok, pop_ok;

    assign full     = (count_q == CountFull);
    assign empty    = (count_q == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/chip8_mem_arb.sv
// Serialises upload writes, blitter and CPU onto the single-port Chip-8 RAM.
// Define CHIP8_ARB_RR_EN for round-robin between blitter and CPU (default: blitter first).
module chip8_mem_arb
    import chip8_mem_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              uploading,
    input  logic              up_we,
    input  logic [ADDR_W-1:0] up_a,
    input  logic [DATA_W-1:0] up_d,
    output logic              up_overflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_d,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_q,
    input  logic              blt_req,
    input  logic              blt_we,
    input  logic [ADDR_W-1:0] blt_a,
    input  logic [DATA_W-1:0] blt_d,
    output logic              blt_ack,
    output logic [DATA_W-1:0] blt_q,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    arb_state_e state_q;
    req_id_e    winner_q;
    logic       uploading_q;
    logic       fifo_full, fifo_empty, fifo_pop;
    up_entry_t  fifo_out, up_entry;
    logic       grant_blt, grant_cpu;
`ifdef CHIP8_ARB_RR_EN
    logic       last_was_blt_q;
`endif

    assign up_entry = {up_a, up_d};
    assign fifo_pop = (state_q == StIdle) && !fifo_empty;
    assign busy     = (state_q != StIdle) || !fifo_empty;

    chip8_mem_arb_upload_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .res_n    (res_n),
        .push     (up_we),
        .push_data(up_entry),
        .pop      (fifo_pop),
        .pop_data (fifo_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // No requester grant in an ack cycle: the acked side is not yet eligible, and holding
    // off one cycle lets it re-request so priority (or round-robin) decides the next tie.
    always_comb begin
        grant_blt = 1'b0;
        grant_cpu = 1'b0;
        if (state_q == StIdle && fifo_empty && !uploading && !blt_ack && !cpu_ack) begin
`ifdef CHIP8_ARB_RR_EN
            if (blt_req && cpu_req) begin
                grant_blt = !last_was_blt_q;
                grant_cpu = last_was_blt_q;
            end else begin
                grant_blt = blt_req;
                grant_cpu = cpu_req;
            end
`else
            grant_blt = blt_req;
            grant_cpu = cpu_req && !blt_req;
`endif
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q        <= StIdle;
            winner_q       <= ReqUpload;
            uploading_q    <= 1'b0;
            up_overflow    <= 1'b0;
            cpu_ack        <= 1'b0;
            blt_ack        <= 1'b0;
            cpu_q          <= '0;
            blt_q          <= '0;
            ram_en         <= 1'b0;
            ram_we         <= 1'b0;
            ram_a          <= '0;
            ram_d          <= '0;
`ifdef CHIP8_ARB_RR_EN
            last_was_blt_q <= 1'b0;
`endif
        end else begin
            cpu_ack     <= 1'b0;
            blt_ack     <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            uploading_q <= uploading;
            if (uploading && !uploading_q) up_overflow <= 1'b0;
            if (up_we && fifo_full)        up_overflow <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (fifo_pop) begin
                        state_q  <= StAccess;
                        winner_q <= ReqUpload;
                        ram_en   <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_a    <= fifo_out.a;
                        ram_d    <= fifo_out.d;
                    end else if (grant_blt) begin
                        state_q  <= StAccess;
                        winner_q <= ReqBlt;
                        ram_en   <= 1'b1;
                        ram_we   <= blt_we;
                        ram_a    <= blt_a;
                        ram_d    <= blt_d;
`ifdef CHIP8_ARB_RR_EN
                        last_was_blt_q <= 1'b1;
`endif
                    end else if (grant_cpu) begin
                        state_q  <= StAccess;
                        winner_q <= ReqCpu;
                        ram_en   <= 1'b1;
                        ram_we   <= cpu_we;
                        ram_a    <= cpu_a;
                        ram_d    <= cpu_d;
`ifdef CHIP8_ARB_RR_EN
                        last_was_blt_q <= 1'b0;
`endif
                    end
                end
                StAccess: begin
                    // ram_we still holds the winner's direction during ACCESS.
                    if (ram_we) begin
                        state_q <= StIdle;
                        blt_ack <= (winner_q == ReqBlt);
                        cpu_ack <= (winner_q == ReqCpu);
                    end else begin
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    state_q <= StIdle;
                    if (winner_q == ReqBlt) begin
                        blt_q   <= ram_q;
                        blt_ack <= 1'b1;
                    end else begin
                        cpu_q   <= ram_q;
                        cpu_ack <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_mem_arb.sv
// Directed self-checking bench for chip8_mem_arb with a behavioural registered RAM.
module tb_chip8_mem_arb;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        uploading = 1'b0, up_we = 1'b0;
    logic [11:0] up_a = '0;
    logic [7:0]  up_d = '0;
    logic        up_overflow;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [11:0] cpu_a = '0;
    logic [7:0]  cpu_d = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_q;
    logic        blt_req = 1'b0, blt_we = 1'b0;
    logic [11:0] blt_a = '0;
    logic [7:0]  blt_d = '0;
    logic        blt_ack;
    logic [7:0]  blt_q;
    logic        ram_en, ram_we;
    logic [11:0] ram_a;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [4096];

    always #5 clk = ~clk;

    chip8_mem_arb #(
        .FIFO_DEPTH(2)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .uploading  (uploading),
        .up_we      (up_we),
        .up_a       (up_a),
        .up_d       (up_d),
        .up_overflow(up_overflow),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_a      (cpu_a),
        .cpu_d      (cpu_d),
        .cpu_ack    (cpu_ack),
        .cpu_q      (cpu_q),
        .blt_req    (blt_req),
        .blt_we     (blt_we),
        .blt_a      (blt_a),
        .blt_d      (blt_d),
        .blt_ack    (blt_ack),
        .blt_q      (blt_q),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_a      (ram_a),
        .ram_d      (ram_d),
        .ram_q      (ram_q),
        .busy       (busy)
    );

    // Registered single-port RAM: read data appears the cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_q <= mem[ram_a];
            if (ram_we) mem[ram_a] = ram_d;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {up_overflow, cpu_ack, blt_ack, ram_en, ram_we, busy, cpu_q, blt_q} |
               {8'h0, ram_a, 4'h0, ram_d};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] seq [6];
        int  n;
        logic got;
        logic early;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'hA2;
        for (int i = 0; i < 6; i++) seq[i] = 2'd0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", all_outs(), 32'h0);
        @(negedge clk) res_n = 1'b1;
        tick();
        chk("idle_outs", all_outs(), 32'h0);

        // CPU read of 0x200
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h200;
        tick();
        chk("rd_ram_en", ram_en, 1'b1);
        chk("rd_ram_a", ram_a, 12'h200);
        chk("rd_ram_we", ram_we, 1'b0);
        chk("rd_busy", busy, 1'b1);
        tick();
        chk("rd_en_off", ram_en, 1'b0);
        chk("rd_no_ack_yet", cpu_ack, 1'b0);
        tick();
        chk("rd_ack", cpu_ack, 1'b1);
        chk("rd_q", cpu_q, 8'hA2);
        cpu_req = 1'b0;
        tick();
        chk("rd_ack_pulse", cpu_ack, 1'b0);
        chk("rd_q_held", cpu_q, 8'hA2);
        chk("rd_not_busy", busy, 1'b0);

        // Blitter write 0x5C to 0x3F0, then CPU read back
        blt_req = 1'b1; blt_we = 1'b1; blt_a = 12'h3F0; blt_d = 8'h5C;
        tick();
        chk("wr_ram_ctl", {ram_en, ram_we}, 2'b11);
        chk("wr_ram_a", ram_a, 12'h3F0);
        chk("wr_ram_d", ram_d, 8'h5C);
        tick();
        chk("wr_ack", blt_ack, 1'b1);
        chk("wr_en_off", ram_en, 1'b0);
        blt_req = 1'b0;
        tick();
        chk("wr_ack_pulse", blt_ack, 1'b0);
        chk("wr_mem", mem[12'h3F0], 8'h5C);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h3F0;
        repeat (3) tick();
        chk("rb_ack", cpu_ack, 1'b1);
        chk("rb_q", cpu_q, 8'h5C);
        cpu_req = 1'b0;
        tick();

        // Continuous contention between blitter and CPU
        blt_req = 1'b1; blt_we = 1'b1; blt_a = 12'h100; blt_d = 8'h11;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 12'h101; cpu_d = 8'h22;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            tick();
            if (blt_ack) begin seq[n] = 2'd1; n++; end
            else if (cpu_ack) begin seq[n] = 2'd2; n++; end
        end
        blt_req = 1'b0; cpu_req = 1'b0;
        chk("arb_count", n, 6);
        for (int i = 0; i < 6; i++) begin
`ifdef CHIP8_ARB_RR_EN
            chk($sformatf("arb_seq%0d", i), seq[i], (i % 2 == 0) ? 2'd1 : 2'd2);
`else
            chk($sformatf("arb_seq%0d", i), seq[i], 2'd1);
`endif
        end
        repeat (2) tick();
        chk("arb_idle", busy, 1'b0);

        // Upload of 16 bytes with a CPU read pending
        uploading = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h205;
        early = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            up_we = 1'b1; up_a = 12'h200 + 12'(i); up_d = 8'(i);
            tick();
            early |= cpu_ack;
            up_we = 1'b0;
            tick();
            early |= cpu_ack;
        end
        repeat (4) begin tick(); early |= cpu_ack; end
        chk("up_no_cpu_ack", early, 1'b0);
        chk("up_no_overflow", up_overflow, 1'b0);
        for (int i = 0; i < 16; i++) chk($sformatf("up_byte%0d", i), mem[12'h200 + 12'(i)], 8'(i));
        uploading = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            tick();
            got = cpu_ack;
        end
        chk("up_cpu_ack_after", got, 1'b1);
        chk("up_cpu_q", cpu_q, 8'h05);
        cpu_req = 1'b0;
        tick();

        // Back-to-back strobes overflow the 2-entry buffer
        uploading = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            up_we = 1'b1; up_a = 12'h300 + 12'(i); up_d = 8'h80 + 8'(i);
            tick();
        end
        up_we = 1'b0;
        chk("ovf_set", up_overflow, 1'b1);
        repeat (6) tick();
        chk("ovf_drained", busy, 1'b0);
        chk("ovf_sticky", up_overflow, 1'b1);
        uploading = 1'b0;
        tick();
        chk("ovf_sticky_fall", up_overflow, 1'b1);
        uploading = 1'b1;
        tick();
        chk("ovf_clear_rise", up_overflow, 1'b0);
        uploading = 1'b0;
        tick();

        // Reset during the ACCESS cycle of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h200;
        tick();
        chk("rst_in_access", ram_en, 1'b1);
        res_n = 1'b0;
        #1;
        chk("rst_outs_zero", all_outs(), 32'h0);
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk) res_n = 1'b1;
        got = 1'b0;
        repeat (5) begin tick(); got |= cpu_ack; end
        chk("rst_no_ack", got, 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h3F0;
        repeat (3) tick();
        chk("rst_fresh_ack", cpu_ack, 1'b1);
        chk("rst_fresh_q", cpu_q, 8'h5C);
        cpu_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
